// File: rtl/divisible_n_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : divisible_n_stream                                                |
// | Streaming remainder-mod-N over W-bit digits with a runtime-loadable        |
// | divisor. Define DIVN_LSB_FIRST_EN for LSB-first digit order.               |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module divisible_n_stream #(
    parameter int W         = 1,
    parameter int NW        = 8,
    parameter int DEFAULT_N = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_sof,
    input  logic          div_load,
    input  logic [NW-1:0] div_value,
    output logic          out_valid,
    output logic          out_div,
    output logic [NW-1:0] out_rem,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [NW-1:0] c_DEF_N = NW'(DEFAULT_N);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [NW-1:0] r_n;
    logic [NW-1:0] r_rem;
    logic [NW-1:0] w_rem_nxt;
    logic [NW-1:0] w_base_rem;
    logic          r_out_valid;
    logic          r_out_div;
    logic          w_accept;
    logic          w_start;

    // Operand a is already reduced, so 2a+b < 2n and one subtract suffices.
    function automatic logic [NW-1:0] f_dbl_add(input logic [NW-1:0] a,
                                                input logic          b,
                                                input logic [NW-1:0] n);
        logic [NW:0] w_sum;
        w_sum = {a, b};
        if (w_sum >= {1'b0, n}) w_sum = w_sum - {1'b0, n};
        return w_sum[NW-1:0];
    endfunction

    assign in_ready = !div_load && (r_state != S_ERR);
    assign w_accept = in_valid && in_ready;
    assign w_start  = in_sof || (r_state == S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        if (div_load) begin
            w_state_nxt = (div_value == '0) ? S_ERR : S_IDLE;
        end else if (w_accept) begin
            w_state_nxt = S_ACC;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

`ifdef DIVN_LSB_FIRST_EN
    localparam logic [NW-1:0] c_DEF_WT = (DEFAULT_N == 1) ? '0 : NW'(1);

    logic [NW-1:0] r_wt;
    logic [NW-1:0] w_wt_nxt;
    logic [NW-1:0] w_base_wt;
    logic [NW-1:0] w_prod;

    function automatic logic [NW-1:0] f_add_mod(input logic [NW-1:0] a,
                                                input logic [NW-1:0] b,
                                                input logic [NW-1:0] n);
        logic [NW:0] w_sum;
        w_sum = {1'b0, a} + {1'b0, b};
        if (w_sum >= {1'b0, n}) w_sum = w_sum - {1'b0, n};
        return w_sum[NW-1:0];
    endfunction

    function automatic logic [NW-1:0] f_one_mod(input logic [NW-1:0] n);
        return (n == NW'(1)) ? '0 : NW'(1);
    endfunction

    // digit*wt mod N by MSB-first shift-and-add, then weight advances by 2^W.
    always_comb begin
        w_base_rem = w_start ? '0 : r_rem;
        w_base_wt  = w_start ? f_one_mod(r_n) : r_wt;
        w_prod     = '0;
        w_wt_nxt   = w_base_wt;
        for (int i = W - 1; i >= 0; i--) begin
            w_prod = f_dbl_add(w_prod, 1'b0, r_n);
            if (in_data[i]) w_prod = f_add_mod(w_prod, w_base_wt, r_n);
        end
        for (int i = 0; i < W; i++) begin
            w_wt_nxt = f_dbl_add(w_wt_nxt, 1'b0, r_n);
        end
        w_rem_nxt = f_add_mod(w_base_rem, w_prod, r_n);
    end
`else
    always_comb begin
        w_base_rem = w_start ? '0 : r_rem;
        w_rem_nxt  = w_base_rem;
        for (int i = W - 1; i >= 0; i--) begin
            w_rem_nxt = f_dbl_add(w_rem_nxt, in_data[i], r_n);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n         <= c_DEF_N;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_out_div   <= 1'b0;
`ifdef DIVN_LSB_FIRST_EN
            r_wt        <= c_DEF_WT;
`endif
        end else if (div_load) begin
            r_n         <= div_value;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_out_div   <= 1'b0;
`ifdef DIVN_LSB_FIRST_EN
            r_wt        <= f_one_mod(div_value);
`endif
        end else begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_rem     <= w_rem_nxt;
                r_out_div <= (w_rem_nxt == '0);
`ifdef DIVN_LSB_FIRST_EN
                r_wt      <= w_wt_nxt;
`endif
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_div   = r_out_div;
    assign out_rem   = r_rem;
    assign err       = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_divisible_n_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_divisible_n_stream                                             |
// | Bench for divisible_n_stream: W=1 and W=4 instances against a model.       |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_divisible_n_stream;

    localparam int NW        = 8;
    localparam int DEFAULT_N = 5;
`ifdef DIVN_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_sof    = 1'b0;
    logic          div_load  = 1'b0;
    logic [NW-1:0] div_value = '0;
    logic [0:0]    d1        = '0;
    logic [3:0]    d4        = '0;

    logic          rdy1, rdy4, ov1, ov4, dv1, dv4, err1, err4;
    logic [NW-1:0] rem1, rem4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    divisible_n_stream #(.W(1), .NW(NW), .DEFAULT_N(DEFAULT_N)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(d1), .in_sof(in_sof), .div_load(div_load),
        .div_value(div_value), .out_valid(ov1), .out_div(dv1),
        .out_rem(rem1), .err(err1)
    );

    divisible_n_stream #(.W(4), .NW(NW), .DEFAULT_N(DEFAULT_N)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
        .in_data(d4), .in_sof(in_sof), .div_load(div_load),
        .div_value(div_value), .out_valid(ov4), .out_div(dv4),
        .out_rem(rem4), .err(err4)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: the number's value modulo N, tracked with plain arithmetic.
    int m_n = DEFAULT_N, m_rem1 = 0, m_rem4 = 0, m_wt1 = 1, m_wt4 = 1;
    bit m_busy = 0, m_err = 0, m_ov = 0, m_div1 = 0, m_div4 = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_n = DEFAULT_N; m_rem1 = 0; m_rem4 = 0;
            m_wt1 = 1 % DEFAULT_N; m_wt4 = 1 % DEFAULT_N;
            m_busy = 0; m_err = 0; m_ov = 0; m_div1 = 0; m_div4 = 0;
        end else if (div_load) begin
            m_n = int'(div_value); m_rem1 = 0; m_rem4 = 0;
            m_busy = 0; m_err = (div_value == 0); m_ov = 0; m_div1 = 0; m_div4 = 0;
        end else if (in_valid && !m_err) begin
            if (in_sof || !m_busy) begin
                m_rem1 = 0; m_rem4 = 0; m_wt1 = 1 % m_n; m_wt4 = 1 % m_n;
            end
            if (LSB) begin
                m_rem1 = (m_rem1 + int'(d1) * m_wt1) % m_n;
                m_wt1  = (m_wt1 * 2) % m_n;
                m_rem4 = (m_rem4 + int'(d4) * m_wt4) % m_n;
                m_wt4  = (m_wt4 * 16) % m_n;
            end else begin
                m_rem1 = (m_rem1 * 2 + int'(d1)) % m_n;
                m_rem4 = (m_rem4 * 16 + int'(d4)) % m_n;
            end
            m_ov = 1; m_busy = 1;
            m_div1 = (m_rem1 == 0); m_div4 = (m_rem4 == 0);
        end else begin
            m_ov = 0;
        end
    end

    always @(negedge clk) begin
        check("out_valid1", int'(ov1), int'(m_ov));
        check("out_valid4", int'(ov4), int'(m_ov));
        check("out_rem1", int'(rem1), m_rem1);
        check("out_rem4", int'(rem4), m_rem4);
        check("out_div1", int'(dv1), int'(m_div1));
        check("out_div4", int'(dv4), int'(m_div4));
        check("err1", int'(err1), int'(m_err));
        check("err4", int'(err4), int'(m_err));
        check("in_ready1", int'(rdy1), int'(!div_load && !m_err));
        check("in_ready4", int'(rdy4), int'(!div_load && !m_err));
    end

    task automatic beat(input logic sof, input logic b, input logic [3:0] d);
        in_valid = 1'b1; in_sof = sof; d1 = b; d4 = d;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic load(input int v, input logic with_valid);
        div_load = 1'b1; div_value = NW'(v); in_valid = with_valid; in_sof = 1'b0;
        #1;
        check("lit_ready_on_load", int'(rdy1), 0);
        @(posedge clk); #1;
        div_load = 1'b0; in_valid = 1'b0;
        check("lit_no_valid_on_load", int'(ov1), 0);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("lit_reset_rem", int'(rem1), 0);
        check("lit_reset_valid", int'(ov4), 0);
        check("lit_reset_err", int'(err1), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // W=1 bits 1,0,1 and W=4 digits 3,C; then a fresh number 7
        beat(1'b1, 1'b1, 4'h3);
        check("lit_a1_rem1", int'(rem1), 1);
        check("lit_a1_rem4", int'(rem4), 3);
        beat(1'b0, 1'b0, 4'hC);
        check("lit_a2_rem1", int'(rem1), LSB ? 1 : 2);
        check("lit_a2_rem4", int'(rem4), 0);
        check("lit_a2_div4", int'(dv4), 1);
        beat(1'b0, 1'b1, 4'h0);
        check("lit_a3_rem1", int'(rem1), 0);
        check("lit_a3_div1", int'(dv1), 1);
        beat(1'b1, 1'b0, 4'h7);
        check("lit_b_rem4", int'(rem4), 2);
        check("lit_b_div4", int'(dv4), 0);
        @(posedge clk); #1;
        check("lit_valid_drops", int'(ov1), 0);
        check("lit_rem_holds", int'(rem4), 2);

        // zero divisor, ignored beats, recovery
        load(0, 1'b0);
        check("lit_err_set", int'(err4), 1);
        repeat (2) begin
            in_valid = 1'b1; in_sof = 1'b1; d1 = 1'b1;
            #1 check("lit_err_ready", int'(rdy4), 0);
            @(posedge clk); #1;
            check("lit_err_no_valid", int'(ov1), 0);
        end
        in_valid = 1'b0; in_sof = 1'b0;
        load(3, 1'b0);
        check("lit_err_clear", int'(err1), 0);
        beat(1'b1, 1'b1, 4'h0);
        check("lit_n3_rem1a", int'(rem1), 1);
        beat(1'b0, 1'b1, 4'h0);
        check("lit_n3_rem1b", int'(rem1), 0);

        // beat offered with div_load is dropped
        load(7, 1'b1);
        beat(1'b1, 1'b1, 4'h9);
        check("lit_n7_rem4", int'(rem4), 2);

        // async reset mid-number
        load(5, 1'b0);
        beat(1'b1, 1'b1, 4'h0);
        beat(1'b0, 1'b1, 4'h0);
        check("lit_pre_rst_rem1", int'(rem1), 3);
        rst = 1'b0;
        #1;
        check("lit_rst_rem1", int'(rem1), 0);
        check("lit_rst_valid", int'(ov1), 0);
        #10 rst = 1'b1;
        @(posedge clk); #1;
        beat(1'b0, 1'b1, 4'h0);
        check("lit_post_rst_a", int'(rem1), 1);
        beat(1'b0, 1'b0, 4'h0);
        check("lit_post_rst_b", int'(rem1), LSB ? 1 : 2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            int rv;
            r  = $urandom_range(0, 99);
            rv = $urandom_range(0, 9);
            div_load  = (r < 4);
            div_value = (rv == 0) ? '0 :
                        (rv == 1) ? NW'($urandom_range(1, 255)) :
                                    NW'($urandom_range(1, 12));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sof    = ($urandom_range(0, 5) == 0);
            d1        = 1'($urandom_range(0, 1));
            d4        = 4'($urandom_range(0, 15));
            if (r >= 98) begin
                rst = 1'b0;
                #3 rst = 1'b1;
            end
            @(posedge clk); #1;
        end
        div_load = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/divisible_n_stream.md
# divisible_n_stream

Parametrised streaming divisibility checker and next-generation serial "divisible by N" detector. Accepts a number as a stream of W-bit digits under a valid/ready handshake and updates the running remainder modulo a runtime-loadable divisor on every accepted beat. Reports the remainder and a divisible flag one cycle after each beat. Sits in the datapath-checking utilities, fed by serialisers or test pattern sources.

## Interface
- W, 1, digit width in bits per beat (radix 2^W), 1..8
- NW, 8, divisor/remainder width in bits
- DEFAULT_N, 5, divisor loaded at reset; must be 1..2^NW-1
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  beat offered
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_data  input  W  digit
- in_sof  input  1  qualifies the beat as the first digit of a new number
- div_load  input  1  load div_value as the new divisor
- div_value  input  NW  divisor value
- out_valid  output  1  one-cycle pulse per accepted beat
- out_div  output  1  running value divisible by N
- out_rem  output  NW  running remainder, always < N
- err  output  1  divisor is zero

## Operation
- States: IDLE (divisor valid, no number in progress, rem=0), ACC (number in progress), ERR (divisor 0).
- Reset: state IDLE, N=DEFAULT_N, rem=0, out_valid=0, out_div=0, out_rem=0, err=0.
- div_load, any state: N<=div_value, rem<=0, weight<=1 mod N. Next state ERR if div_value==0, else IDLE. err follows.
- in_ready = !div_load && state!=ERR (combinational). A beat offered together with div_load is not accepted.
- Accepted beat with in_sof, or any accepted beat in IDLE: rem starts from 0; the beat is the first digit. State becomes ACC.
- Accepted beat in ACC without in_sof: extends the current number.
- MSB-first update: rem_next = (rem*2^W + in_data) mod N. Computed as W restoring steps: r=2r+bit, then subtract N if r>=N. Intermediate width NW+1.
- in_data >= N is legal. N=1 gives rem=0 and out_div=1 on every beat.
- ERR is left only by div_load with a non-zero value. in_valid is ignored in ERR.
- No end-of-number marker. The result for a number is the output of its last beat.

## Timing
- Latency 1: the beat accepted at edge k produces out_valid=1, out_rem and out_div at edge k+1.
- out_valid deasserts the cycle after, unless another beat is accepted. out_rem and out_div hold between beats.
- Full throughput: one beat per cycle.
- div_load takes effect at the next edge. out_rem and out_div clear at that same edge, with no out_valid pulse.
- Asynchronous rst low mid-number: all state returns to reset values immediately. The partial number is discarded. The first accepted beat after release starts a new number.

## Configuration
- DIVN_LSB_FIRST_EN defined: digits arrive LSB-first.
  - A weight register wt (NW bits) is reset to 1 mod N on reset, div_load, in_sof and the IDLE start.
  - rem_next = (rem + in_data*wt) mod N; wt_next = (wt*2^W) mod N.
  - Both updates are computed as bounded shift-subtract loops, with the same latency.
- Undefined: MSB-first, as above. No wt register.

## Test plan
- W=1, N=5, MSB-first, bits 1,0,1 (sof on first) -> out_rem 1,2,0; out_div 0,0,1 on successive out_valid pulses.
- W=4, N=5, digits 0x3,0xC (=60) -> out_rem 3 then 0; out_div=1 on second pulse. Back-to-back sof 0x7 -> out_rem 2, out_div=0.
- div_load with 0 -> err=1, in_ready=0, in_valid beats produce no out_valid. div_load 3 -> err=0. Beats 1,1 (W=1) -> rem 1,0.
- div_load with in_valid asserted in the same cycle -> in_ready=0, beat dropped, no out_valid. Next beat with sof computed against the new N.
- rst pulsed low after bits 1,1 (N=5, rem 3) -> outputs 0 immediately. After release, bits 1,0 -> rem 1,2.
- DIVN_LSB_FIRST_EN, W=1, N=5, bits 1,0,1 LSB-first (=5) -> out_rem 1,1,0; out_div=1 on third. W=2, N=7, digits 2,3 (=14) -> rem 2,0.
